cnn_layer_accel_job_ctrl: RTL and testbench

//  Multi-quad job sequencer. Accepts one job descriptor at a time and broadcasts it to a mask-selected set of
//  C_NUM_QUADS accelerator quads. It runs each quad's job_start/accept, fetch request/ack/complete and

---
 rtl/cnn_layer_accel_job_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_cnn_layer_accel_job_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Multi-quad job sequencer: broadcasts one job descriptor to a mask-selected set of quads,
// runs their start/fetch/complete handshakes and funnels fetch requests onto one DMA port.
//
//  state         | meaning
//  S_IDLE        | ready for a host descriptor
//  S_WAIT_ACCEPT | job_start asserted, collecting per-quad accepts
//  S_RUN         | quads working; arbitrate fetches, collect completions
//  S_FETCH_ISSUE | DMA command presented, waiting for fetch_ready
//  S_FETCH_WAIT  | DMA command in flight, waiting for fetch_done
//  S_COMPLETE    | one-cycle completion ack/done
module cnn_layer_accel_job_ctrl #(
  parameter int C_NUM_QUADS   = 4,
  parameter int C_PARAM_WIDTH = 128,
  parameter int C_TIMEOUT     = 4096
) (
  input  logic                     clk_if,
  input  logic                     rst,
  input  logic                     job_in_valid,
  output logic                     job_in_ready,
  input  logic [C_PARAM_WIDTH-1:0] job_in_params,
  input  logic [C_NUM_QUADS-1:0]   job_in_mask,
  output logic [C_NUM_QUADS-1:0]   job_start,
  input  logic [C_NUM_QUADS-1:0]   job_accept,
  output logic [C_PARAM_WIDTH-1:0] job_parameters,
  input  logic [C_NUM_QUADS-1:0]   job_fetch_request,
  output logic [C_NUM_QUADS-1:0]   job_fetch_ack,
  output logic [C_NUM_QUADS-1:0]   job_fetch_complete,
  input  logic [C_NUM_QUADS-1:0]   job_complete,
  output logic [C_NUM_QUADS-1:0]   job_complete_ack,
  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [((C_NUM_QUADS > 1) ? $clog2(C_NUM_QUADS) : 1)-1:0] fetch_quad_id,
  input  logic                     fetch_done,
  output logic                     job_done,
  output logic                     job_timeout
);

  localparam int QW      = (C_NUM_QUADS > 1) ? $clog2(C_NUM_QUADS) : 1;
  localparam int WD_W    = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam int WD_LAST = (C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0;
  localparam logic [C_NUM_QUADS-1:0] QUAD_LSB = C_NUM_QUADS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ACCEPT,
    S_RUN,
    S_FETCH_ISSUE,
    S_FETCH_WAIT,
    S_COMPLETE
  } state_t;

  state_t state, state_nxt;

  logic [C_NUM_QUADS-1:0] mask_q;
  logic [C_NUM_QUADS-1:0] accepted_q;
  logic [C_NUM_QUADS-1:0] seen_q;
  logic [QW-1:0]          rr_ptr;
  logic [WD_W-1:0]        wd_cnt;
  logic [WD_W-1:0]        wd_nxt;

  logic                   job_take;
  logic [C_NUM_QUADS-1:0] accept_hit;
  logic [C_NUM_QUADS-1:0] seen_nxt;
  logic [C_NUM_QUADS-1:0] fetch_elig;
  logic                   wd_active;
  logic                   wd_hit;
  logic                   grant_found;
  logic [QW-1:0]          grant_idx;
  logic [QW-1:0]          grant_probe;
  logic [C_NUM_QUADS-1:0] grant_oh;
  logic [C_NUM_QUADS-1:0] active_oh;

  logic                   ready_nxt;
  logic [C_NUM_QUADS-1:0] start_nxt;
  logic [C_NUM_QUADS-1:0] fetch_ack_nxt;
  logic                   fetch_valid_nxt;
  logic [QW-1:0]          quad_id_nxt;
  logic [C_NUM_QUADS-1:0] fetch_cmpl_nxt;
  logic [C_NUM_QUADS-1:0] cmpl_ack_nxt;
  logic                   done_nxt;
  logic                   timeout_nxt;

  assign job_take   = job_in_valid & job_in_ready;
  assign accept_hit = job_accept & mask_q;
  assign seen_nxt   = seen_q | (job_complete & mask_q);
  // Quads already seen complete cannot win a fetch slot.
  assign fetch_elig = job_fetch_request & mask_q & ~seen_q;
  assign wd_active  = (state == S_WAIT_ACCEPT) || (state == S_FETCH_WAIT);
  assign wd_hit     = (C_TIMEOUT != 0) && wd_active && (wd_cnt == WD_W'(WD_LAST));
  assign grant_oh   = QUAD_LSB << grant_idx;
  assign active_oh  = QUAD_LSB << rr_ptr;

  // Round-robin search begins one past the last granted quad.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_probe = '0;
    for (int i = 1; i <= C_NUM_QUADS; i++) begin
      grant_probe = QW'((int'(rr_ptr) + i) % C_NUM_QUADS);
      if (!grant_found && fetch_elig[grant_probe]) begin
        grant_found = 1'b1;
        grant_idx   = grant_probe;
      end
    end
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (job_take && (job_in_mask != '0)) state_nxt = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        if ((accepted_q | accept_hit) == mask_q) state_nxt = S_RUN;
        else if (wd_hit)                         state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (grant_found)              state_nxt = S_FETCH_ISSUE;
        else if (seen_nxt == mask_q)  state_nxt = S_COMPLETE;
      end
      S_FETCH_ISSUE: begin
        if (fetch_ready) state_nxt = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (fetch_done)  state_nxt = S_RUN;
        else if (wd_hit) state_nxt = S_IDLE;
      end
      S_COMPLETE: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    if (state_nxt != state) wd_nxt = '0;
    else if (wd_active)     wd_nxt = wd_cnt + 1'b1;
    else                    wd_nxt = '0;
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      mask_q         <= '0;
      job_parameters <= '0;
      accepted_q     <= '0;
      seen_q         <= '0;
      rr_ptr         <= '0;
      wd_cnt         <= '0;
    end else begin
      if (job_take) begin
        job_parameters <= job_in_params;
        mask_q         <= job_in_mask;
        accepted_q     <= '0;
        seen_q         <= '0;
      end
      if (state == S_WAIT_ACCEPT) accepted_q <= accepted_q | accept_hit;
      if (state == S_RUN) begin
        seen_q <= seen_nxt;
        if (grant_found) rr_ptr <= grant_idx;
      end
      wd_cnt <= wd_nxt;
    end
  end

  // Outputs are computed from the transition being taken and registered,
  // so each strobe appears in the first cycle of the state it belongs to.
  always_comb begin
    ready_nxt = (state_nxt == S_IDLE);
    start_nxt = '0;
    if (state == S_IDLE && state_nxt == S_WAIT_ACCEPT) begin
      start_nxt = job_in_mask;
    end else if (state == S_WAIT_ACCEPT && state_nxt == S_WAIT_ACCEPT) begin
      start_nxt = job_start & ~accept_hit;
    end
    fetch_ack_nxt   = (state == S_RUN && grant_found) ? grant_oh : '0;
    fetch_valid_nxt = (state_nxt == S_FETCH_ISSUE);
    quad_id_nxt     = (state == S_RUN && grant_found) ? grant_idx : fetch_quad_id;
    fetch_cmpl_nxt  = (state == S_FETCH_WAIT && fetch_done) ? active_oh : '0;
    cmpl_ack_nxt    = (state == S_RUN && state_nxt == S_COMPLETE) ? mask_q : '0;
    done_nxt        = (state == S_RUN && state_nxt == S_COMPLETE) ||
                      (job_take && (job_in_mask == '0));
    timeout_nxt     = wd_active && (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      job_in_ready       <= 1'b1;
      job_start          <= '0;
      job_fetch_ack      <= '0;
      fetch_valid        <= 1'b0;
      fetch_quad_id      <= '0;
      job_fetch_complete <= '0;
      job_complete_ack   <= '0;
      job_done           <= 1'b0;
      job_timeout        <= 1'b0;
    end else begin
      job_in_ready       <= ready_nxt;
      job_start          <= start_nxt;
      job_fetch_ack      <= fetch_ack_nxt;
      fetch_valid        <= fetch_valid_nxt;
      fetch_quad_id      <= quad_id_nxt;
      job_fetch_complete <= fetch_cmpl_nxt;
      job_complete_ack   <= cmpl_ack_nxt;
      job_done           <= done_nxt;
      job_timeout        <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Self-checking bench for cnn_layer_accel_job_ctrl: four quads, 16-cycle watchdog,
// expectations from a round-robin/handshake timing model kept in the bench.
module tb_cnn_layer_accel_job_ctrl;
  localparam int N  = 4;
  localparam int PW = 32;
  localparam int TO = 16;

  logic          clk_if = 1'b0;
  logic          rst;
  logic          job_in_valid;
  logic          job_in_ready;
  logic [PW-1:0] job_in_params;
  logic [N-1:0]  job_in_mask;
  logic [N-1:0]  job_start;
  logic [N-1:0]  job_accept;
  logic [PW-1:0] job_parameters;
  logic [N-1:0]  job_fetch_request;
  logic [N-1:0]  job_fetch_ack;
  logic [N-1:0]  job_fetch_complete;
  logic [N-1:0]  job_complete;
  logic [N-1:0]  job_complete_ack;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [1:0]    fetch_quad_id;
  logic          fetch_done;
  logic          job_done;
  logic          job_timeout;

  int total = 0;
  int bad   = 0;
  int rr_model = 0;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_job_ctrl #(.C_NUM_QUADS(N), .C_PARAM_WIDTH(PW), .C_TIMEOUT(TO)) dut (
    .clk_if(clk_if), .rst(rst),
    .job_in_valid(job_in_valid), .job_in_ready(job_in_ready),
    .job_in_params(job_in_params), .job_in_mask(job_in_mask),
    .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
    .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
    .job_fetch_complete(job_fetch_complete), .job_complete(job_complete),
    .job_complete_ack(job_complete_ack), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_quad_id(fetch_quad_id), .fetch_done(fetch_done),
    .job_done(job_done), .job_timeout(job_timeout)
  );

  task automatic tick;
    @(negedge clk_if);
  endtask

  task automatic idle_inputs;
    job_in_valid = 0; job_in_params = '0; job_in_mask = '0; job_accept = '0;
    job_fetch_request = '0; job_complete = '0; fetch_ready = 0; fetch_done = 0;
  endtask

  // Next quad in round-robin order after rr among the pending set.
  function automatic int next_grant(input logic [N-1:0] pend, input int rr);
    logic [1:0] k;
    for (int i = 1; i <= N; i++) begin
      k = 2'((rr + i) % N);
      if (pend[k]) return int'(k);
    end
    return -1;
  endfunction

  task automatic start_job(input logic [N-1:0] m, input logic [PW-1:0] p);
    total++;
    if (job_in_ready !== 1'b1) begin
      bad++; $display("FAIL start_ready got=%0b exp=1", job_in_ready);
    end
    job_in_valid = 1; job_in_mask = m; job_in_params = p;
    tick;
    job_in_valid = 0; job_in_mask = 4'($urandom); job_in_params = $urandom;
    total++;
    if (job_parameters !== p) begin
      bad++; $display("FAIL params got=%0h exp=%0h", job_parameters, p);
    end
    total++;
    if ({job_in_ready, job_done, job_start} !== {m == 0, m == 0, m}) begin
      bad++; $display("FAIL job_launch got=%0b_%0b_%b exp=%0b_%0b_%b",
                      job_in_ready, job_done, job_start, m == 0, m == 0, m);
    end
  endtask

  // Each quad q pulses accept d[q] cycles after job_start is first visible.
  task automatic accept_phase(input logic [N-1:0] m, input int d [N], input logic [N-1:0] early);
    int dmax = 0;
    logic [N-1:0] exp_start;
    for (int q = 0; q < N; q++) if (m[q] && d[q] > dmax) dmax = d[q];
    job_fetch_request = early;
    for (int t = 0; t <= dmax + 1; t++) begin
      for (int q = 0; q < N; q++) exp_start[q] = m[q] && (t <= d[q]);
      total++;
      if ({job_start, job_fetch_ack} !== {exp_start, 4'b0}) begin
        bad++; $display("FAIL accept_t%0d start/ack got=%b/%b exp=%b/0000",
                        t, job_start, job_fetch_ack, exp_start);
      end
      for (int q = 0; q < N; q++) job_accept[q] = m[q] && (t == d[q]);
      tick;
    end
    job_accept = '0;
  endtask

  task automatic fetch_phase(input logic [N-1:0] reqs, input bit pre, input bit poke_done,
                             input int rd_fix);
    logic [N-1:0] pend = reqs;
    logic [N-1:0] oh;
    int g, rd, dd;
    if (!pre) begin
      job_fetch_request = reqs;
      tick;
    end
    while (pend != 0) begin
      g = next_grant(pend, rr_model);
      rr_model = g;
      oh = 4'b0001 << g;
      total++;
      if ({job_fetch_ack, fetch_valid, fetch_quad_id} !== {oh, 1'b1, 2'(g)}) begin
        bad++; $display("FAIL grant ack/valid/id got=%b/%0b/%0d exp=%b/1/%0d",
                        job_fetch_ack, fetch_valid, fetch_quad_id, oh, g);
      end
      pend[g] = 1'b0;
      job_fetch_request[g] = 1'b0;
      rd = (rd_fix < 0) ? $urandom_range(0, 3) : rd_fix;
      for (int k = 0; k < rd; k++) begin
        fetch_done = poke_done && (k == 0);
        tick;
        fetch_done = 0;
        total++;
        if ({job_fetch_ack, fetch_valid, fetch_quad_id, job_fetch_complete} !== {4'b0, 1'b1, 2'(g), 4'b0}) begin
          bad++; $display("FAIL stall ack/valid/id/cmpl got=%b/%0b/%0d/%b exp=0000/1/%0d/0000",
                          job_fetch_ack, fetch_valid, fetch_quad_id, job_fetch_complete, g);
        end
      end
      fetch_ready = 1;
      tick;
      fetch_ready = 0;
      total++;
      if ({job_fetch_ack, fetch_valid, job_fetch_complete} !== 9'b0) begin
        bad++; $display("FAIL issue_exit ack/valid/cmpl got=%b/%0b/%b exp=0000/0/0000",
                        job_fetch_ack, fetch_valid, job_fetch_complete);
      end
      dd = $urandom_range(0, 5);
      for (int k = 0; k < dd; k++) begin
        tick;
        total++;
        if ({job_fetch_complete, job_timeout} !== 5'b0) begin
          bad++; $display("FAIL fetch_wait cmpl/timeout got=%b/%0b exp=0000/0",
                          job_fetch_complete, job_timeout);
        end
      end
      fetch_done = 1;
      tick;
      fetch_done = 0;
      total++;
      if ({job_fetch_complete, fetch_valid} !== {oh, 1'b0}) begin
        bad++; $display("FAIL fetch_complete got=%b exp=%b", job_fetch_complete, oh);
      end
      if (pend != 0) tick;
    end
  endtask

  task automatic complete_phase(input logic [N-1:0] m, input logic [N-1:0] first);
    if (first != 0 && first != m) begin
      job_complete = first;
      tick;
      total++;
      if ({job_complete_ack, job_done} !== 5'b0) begin
        bad++; $display("FAIL partial_complete ack/done got=%b/%0b exp=0000/0",
                        job_complete_ack, job_done);
      end
    end
    job_complete = m;
    tick;
    total++;
    if ({job_complete_ack, job_done, job_in_ready} !== {m, 1'b1, 1'b0}) begin
      bad++; $display("FAIL complete ack/done/ready got=%b/%0b/%0b exp=%b/1/0",
                      job_complete_ack, job_done, job_in_ready, m);
    end
    job_complete = '0;
    tick;
    total++;
    if ({job_complete_ack, job_done, job_in_ready} !== {4'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL post_complete ack/done/ready got=%b/%0b/%0b exp=0000/0/1",
                      job_complete_ack, job_done, job_in_ready);
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if ({job_in_ready, job_start, job_parameters, job_fetch_ack, job_fetch_complete,
         job_complete_ack, fetch_valid, fetch_quad_id, job_done, job_timeout} !== {1'b1, 53'd0}) begin
      bad++; $display("FAIL %s outputs got=%0b_%b_%0h_%b_%b_%b_%0b_%0d_%0b_%0b exp=ready_only",
                      tag, job_in_ready, job_start, job_parameters, job_fetch_ack, job_fetch_complete,
                      job_complete_ack, fetch_valid, fetch_quad_id, job_done, job_timeout);
    end
  endtask

  task automatic test_reset;
    idle_inputs;
    rst = 1;
    repeat (2) tick;
    check_reset_values("reset_held");
    rst = 0;
    tick;
    check_reset_values("reset_released");
    rr_model = 0;
  endtask

  // T1: staggered accepts; an early fetch request must not be granted before RUN.
  task automatic test_accept_order;
    int d[N];
    d = '{1, 0, 3, 0};
    start_job(4'b0101, 32'hA5A5_0001);
    accept_phase(4'b0101, d, 4'b0001);
    fetch_phase(4'b0001, 1, 0, -1);
    complete_phase(4'b0101, 4'b0000);
  endtask

  // T2: with rr at 0, quads 0,1,3 requesting together are granted 1,3,0.
  task automatic test_grant_order;
    int d[N];
    d = '{0, 0, 0, 0};
    start_job(4'b1111, 32'h1234_5678);
    accept_phase(4'b1111, d, 4'b0000);
    fetch_phase(4'b1011, 0, 0, -1);
    total++;
    if (rr_model !== 0) begin
      bad++; $display("FAIL rr_last got=%0d exp=0", rr_model);
    end
    complete_phase(4'b1111, 4'b0000);
  endtask

  // T3: fetch_ready low 5 cycles with a stray fetch_done in FETCH_ISSUE.
  task automatic test_fetch_stall;
    int d[N];
    d = '{0, 0, 2, 0};
    start_job(4'b0100, 32'hDEAD_BEEF);
    accept_phase(4'b0100, d, 4'b0000);
    fetch_phase(4'b0100, 0, 1, 5);
    complete_phase(4'b0100, 4'b0000);
  endtask

  // T4: staggered completion, single ack cycle, ready the cycle after.
  task automatic test_complete;
    int d[N];
    d = '{2, 1, 0, 0};
    start_job(4'b0011, 32'h0000_00C4);
    accept_phase(4'b0011, d, 4'b0000);
    complete_phase(4'b0011, 4'b0010);
  endtask

  // T5: no accept -> timeout exactly 16 cycles after WAIT_ACCEPT entry.
  task automatic test_accept_timeout;
    start_job(4'b0010, 32'h0BAD_CAFE);
    for (int t = 0; t < TO; t++) begin
      total++;
      if ({job_timeout, job_start} !== {1'b0, 4'b0010}) begin
        bad++; $display("FAIL wa_wait_t%0d timeout/start got=%0b/%b exp=0/0010", t, job_timeout, job_start);
      end
      tick;
    end
    total++;
    if ({job_timeout, job_start, job_in_ready, job_done} !== {1'b1, 4'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wa_timeout timeout/start/ready/done got=%0b/%b/%0b/%0b exp=1/0000/1/0",
                      job_timeout, job_start, job_in_ready, job_done);
    end
    tick;
    total++;
    if (job_timeout !== 1'b0) begin
      bad++; $display("FAIL wa_timeout_pulse got=%0b exp=0", job_timeout);
    end
  endtask

  task automatic test_fetch_timeout;
    int d[N];
    d = '{0, 0, 0, 0};
    start_job(4'b0001, 32'h7777_0000);
    accept_phase(4'b0001, d, 4'b0000);
    job_fetch_request = 4'b0001;
    tick;
    rr_model = next_grant(4'b0001, rr_model);
    total++;
    if ({job_fetch_ack, fetch_valid} !== {4'b0001, 1'b1}) begin
      bad++; $display("FAIL fw_grant got=%b/%0b exp=0001/1", job_fetch_ack, fetch_valid);
    end
    job_fetch_request = '0;
    fetch_ready = 1;
    tick;
    fetch_ready = 0;
    for (int t = 0; t < TO; t++) begin
      total++;
      if (job_timeout !== 1'b0) begin
        bad++; $display("FAIL fw_wait_t%0d timeout got=1 exp=0", t);
      end
      tick;
    end
    total++;
    if ({job_timeout, job_in_ready, job_fetch_complete} !== {1'b1, 1'b1, 4'b0}) begin
      bad++; $display("FAIL fw_timeout timeout/ready/cmpl got=%0b/%0b/%b exp=1/1/0000",
                      job_timeout, job_in_ready, job_fetch_complete);
    end
    fetch_done = 1;
    tick;
    fetch_done = 0;
    total++;
    if ({job_fetch_complete, job_done, job_timeout} !== 6'b0) begin
      bad++; $display("FAIL late_done cmpl/done/timeout got=%b/%0b/%0b exp=0000/0/0",
                      job_fetch_complete, job_done, job_timeout);
    end
  endtask

  // T6: empty mask finishes at once; reset in FETCH_WAIT aborts silently.
  task automatic test_empty_and_reset;
    int d[N];
    start_job(4'b0000, 32'h0000_5EED);
    tick;
    total++;
    if ({job_done, job_start, job_in_ready} !== {1'b0, 4'b0, 1'b1}) begin
      bad++; $display("FAIL empty_after done/start/ready got=%0b/%b/%0b exp=0/0000/1",
                      job_done, job_start, job_in_ready);
    end
    d = '{0, 0, 0, 1};
    start_job(4'b1000, 32'hFACE_0FF0);
    accept_phase(4'b1000, d, 4'b0000);
    job_fetch_request = 4'b1000;
    tick;
    job_fetch_request = '0;
    fetch_ready = 1;
    tick;
    fetch_ready = 0;
    rst = 1;
    #1;
    check_reset_values("reset_mid_job");
    tick;
    rst = 0;
    idle_inputs;
    rr_model = 0;
    for (int t = 0; t < 4; t++) begin
      tick;
      total++;
      if ({job_done, job_timeout, job_in_ready} !== 3'b001) begin
        bad++; $display("FAIL after_reset_t%0d done/timeout/ready got=%0b/%0b/%0b exp=0/0/1",
                        t, job_done, job_timeout, job_in_ready);
      end
    end
  endtask

  task automatic test_random_jobs;
    int d[N];
    logic [N-1:0] m, r;
    for (int j = 0; j < 12; j++) begin
      m = 4'($urandom_range(1, 15));
      start_job(m, $urandom);
      for (int q = 0; q < N; q++) d[q] = $urandom_range(0, 4);
      accept_phase(m, d, 4'b0000);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        r = 4'($urandom) & m;
        if (r != 0) fetch_phase(r, 0, 1'($urandom_range(0, 1)), -1);
      end
      complete_phase(m, 4'($urandom) & m);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs;
    test_reset;
    test_accept_order;
    test_grant_order;
    test_fetch_stall;
    test_complete;
    test_accept_timeout;
    test_fetch_timeout;
    test_empty_and_reset;
    test_random_jobs;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
